// File: rtl/colorDetect_pkg.sv
// Shared colour-detection types: colour codes, region count, stabiliser FSM states.
// Build option COLOR_STAB_HOLD_UNKNOWN_EN: CODE_UNKNOWN counts as "no evidence".
package colorDetect_pkg;

    typedef logic [2:0] color_t;

    localparam color_t CODE_RED     = 3'd0;
    localparam color_t CODE_ORANGE  = 3'd1;
    localparam color_t CODE_YELLOW  = 3'd2;
    localparam color_t CODE_GREEN   = 3'd3;
    localparam color_t CODE_BLUE    = 3'd4;
    localparam color_t CODE_WHITE   = 3'd5;
    localparam color_t CODE_UNKNOWN = 3'd7;

    localparam int NUM_REGIONS = 9;
    localparam int SNAP_W      = 3 * NUM_REGIONS;

`ifdef COLOR_STAB_HOLD_UNKNOWN_EN
    localparam bit HOLD_UNKNOWN = 1'b1;
`else
    localparam bit HOLD_UNKNOWN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } stab_state_t;

endpackage

// File: rtl/color_stabilizer_if.sv
// Frame strobe and raw region codes in; stabilised codes and status out.
interface color_stabilizer_if;
    import colorDetect_pkg::*;

    logic   i_frame_strobe;
    color_t i_color0;
    color_t i_color1;
    color_t i_color2;
    color_t i_color3;
    color_t i_color4;
    color_t i_color5;
    color_t i_color6;
    color_t i_color7;
    color_t i_color8;

    color_t o_color0;
    color_t o_color1;
    color_t o_color2;
    color_t o_color3;
    color_t o_color4;
    color_t o_color5;
    color_t o_color6;
    color_t o_color7;
    color_t o_color8;
    logic   o_update;
    logic   o_all_stable;
    logic   o_busy;
    logic   o_overrun;

    modport master (
        output i_frame_strobe,
        output i_color0, i_color1, i_color2,
        output i_color3, i_color4, i_color5,
        output i_color6, i_color7, i_color8,
        input  o_color0, o_color1, o_color2,
        input  o_color3, o_color4, o_color5,
        input  o_color6, o_color7, o_color8,
        input  o_update, o_all_stable,
        input  o_busy, o_overrun
    );

    modport slave (
        input  i_frame_strobe,
        input  i_color0, i_color1, i_color2,
        input  i_color3, i_color4, i_color5,
        input  i_color6, i_color7, i_color8,
        output o_color0, o_color1, o_color2,
        output o_color3, o_color4, o_color5,
        output o_color6, o_color7, o_color8,
        output o_update, o_all_stable,
        output o_busy, o_overrun
    );

endinterface

// File: rtl/color_stabilizer.sv
// Temporal filter for nine region colour codes, one region per cycle per frame.
// Build option COLOR_STAB_HOLD_UNKNOWN_EN: unknown codes leave agreement untouched.
module color_stabilizer
    import colorDetect_pkg::*;
#(
    parameter int STABLE_FRAMES = 4,
    parameter int CNT_W         = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    color_stabilizer_if.slave  bus
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SAT  = cnt_t'(STABLE_FRAMES);
    localparam logic [3:0] LAST = 4'(NUM_REGIONS - 1);

    stab_state_t state;
    stab_state_t state_nxt;

    logic [SNAP_W-1:0] snap;
    logic [3:0]        idx;
    logic [4:0]        base;

    color_t cand [NUM_REGIONS];
    cnt_t   cnt  [NUM_REGIONS];
    color_t outc [NUM_REGIONS];

    logic changed;
    logic upd_stage;
    logic update_q;
    logic all_stable_q;
    logic overrun_q;

    logic [NUM_REGIONS-1:0] at_sat;

    color_t cur_snap;
    color_t cand_nxt;
    cnt_t   cnt_nxt;
    color_t out_nxt;
    logic   chg_nxt;

    function automatic void region_step(
        input  color_t s,
        input  color_t c,
        input  cnt_t   n,
        input  color_t o,
        output color_t c_n,
        output cnt_t   n_n,
        output color_t o_n,
        output logic   chg
    );
        c_n = c;
        n_n = n;
        o_n = o;
        chg = 1'b0;
        if (!(HOLD_UNKNOWN && s == CODE_UNKNOWN)) begin
            if (s == c) begin
                if (n < SAT)
                    n_n = n + cnt_t'(1);
            end else begin
                c_n = s;
                n_n = cnt_t'(1);
            end
            if (n_n == SAT && o != c_n) begin
                o_n = c_n;
                chg = 1'b1;
            end
        end
    endfunction

    // region idx lives at bits [3*idx +: 3] of the snapshot
    assign base     = {1'b0, idx} + {idx, 1'b0};
    assign cur_snap = snap[base +: 3];

    always_comb begin
        cand_nxt = CODE_UNKNOWN;
        cnt_nxt  = '0;
        out_nxt  = CODE_UNKNOWN;
        chg_nxt  = 1'b0;
        region_step(cur_snap, cand[idx], cnt[idx], outc[idx],
                    cand_nxt, cnt_nxt, out_nxt, chg_nxt);
    end

    always_comb begin
        at_sat = '0;
        for (int i = 0; i < NUM_REGIONS; i++)
            at_sat[i] = (cnt[i] == SAT);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (bus.i_frame_strobe) state_nxt = ST_SCAN;
            ST_SCAN: if (idx == LAST)        state_nxt = ST_DONE;
            ST_DONE:                         state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            snap         <= {NUM_REGIONS{CODE_UNKNOWN}};
            idx          <= '0;
            changed      <= 1'b0;
            upd_stage    <= 1'b0;
            update_q     <= 1'b0;
            all_stable_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                cand[i] <= CODE_UNKNOWN;
                cnt[i]  <= '0;
                outc[i] <= CODE_UNKNOWN;
            end
        end else begin
            upd_stage <= 1'b0;
            update_q  <= upd_stage;
            if (state == ST_IDLE && bus.i_frame_strobe) begin
                snap <= {bus.i_color8, bus.i_color7, bus.i_color6,
                         bus.i_color5, bus.i_color4, bus.i_color3,
                         bus.i_color2, bus.i_color1, bus.i_color0};
                idx  <= '0;
            end
            // a strobe during a scan is dropped; the scan carries on
            if (state != ST_IDLE && bus.i_frame_strobe)
                overrun_q <= 1'b1;
            if (state == ST_SCAN) begin
                cand[idx] <= cand_nxt;
                cnt[idx]  <= cnt_nxt;
                outc[idx] <= out_nxt;
                if (chg_nxt)
                    changed <= 1'b1;
                idx <= idx + 4'd1;
            end
            if (state == ST_DONE) begin
                upd_stage    <= changed;
                changed      <= 1'b0;
                all_stable_q <= &at_sat;
            end
        end
    end

    assign bus.o_color0     = outc[0];
    assign bus.o_color1     = outc[1];
    assign bus.o_color2     = outc[2];
    assign bus.o_color3     = outc[3];
    assign bus.o_color4     = outc[4];
    assign bus.o_color5     = outc[5];
    assign bus.o_color6     = outc[6];
    assign bus.o_color7     = outc[7];
    assign bus.o_color8     = outc[8];
    assign bus.o_update     = update_q;
    assign bus.o_all_stable = all_stable_q;
    assign bus.o_busy       = (state != ST_IDLE);
    assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_color_stabilizer.sv
// Bench for color_stabilizer: two instances (STABLE_FRAMES 4 and 1) against a
// run-length history model of each region.
module tb_color_stabilizer;
    import colorDetect_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #4 clk = ~clk;

    color_stabilizer_if if4 ();
    color_stabilizer_if if1 ();

    color_stabilizer #(.STABLE_FRAMES(4), .CNT_W(8)) u_sf4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if4.slave)
    );

    color_stabilizer #(.STABLE_FRAMES(1), .CNT_W(8)) u_sf1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if1.slave)
    );

    color_t hist [2][NUM_REGIONS][$];
    color_t mout [2][NUM_REGIONS];
    int     sfm  [2] = '{4, 1};
    logic   exp_upd [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input int m, input logic s, input logic [26:0] f);
        if (m == 0) begin
            if4.i_frame_strobe = s;
            {if4.i_color8, if4.i_color7, if4.i_color6, if4.i_color5, if4.i_color4,
             if4.i_color3, if4.i_color2, if4.i_color1, if4.i_color0} = f;
        end else begin
            if1.i_frame_strobe = s;
            {if1.i_color8, if1.i_color7, if1.i_color6, if1.i_color5, if1.i_color4,
             if1.i_color3, if1.i_color2, if1.i_color1, if1.i_color0} = f;
        end
    endtask

    function automatic logic [26:0] outs(input int m);
        if (m == 0)
            return {if4.o_color8, if4.o_color7, if4.o_color6, if4.o_color5, if4.o_color4,
                    if4.o_color3, if4.o_color2, if4.o_color1, if4.o_color0};
        return {if1.o_color8, if1.o_color7, if1.o_color6, if1.o_color5, if1.o_color4,
                if1.o_color3, if1.o_color2, if1.o_color1, if1.o_color0};
    endfunction

    function automatic logic upd(input int m);
        return (m == 0) ? if4.o_update : if1.o_update;
    endfunction

    function automatic logic busy(input int m);
        return (m == 0) ? if4.o_busy : if1.o_busy;
    endfunction

    function automatic logic ovr(input int m);
        return (m == 0) ? if4.o_overrun : if1.o_overrun;
    endfunction

    function automatic logic alls(input int m);
        return (m == 0) ? if4.o_all_stable : if1.o_all_stable;
    endfunction

    // model: a region's agreement is the length of the trailing run of equal codes
    function automatic int run_len(input int m, input int r);
        int n = 0;
        int sz = hist[m][r].size();
        for (int i = sz - 1; i >= 0; i--) begin
            if (hist[m][r][i] == hist[m][r][sz-1]) n++;
            else break;
        end
        return n;
    endfunction

    function automatic void model_reset();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < NUM_REGIONS; r++) begin
                hist[m][r].delete();
                mout[m][r] = CODE_UNKNOWN;
            end
    endfunction

    function automatic logic model_frame(input int m, input logic [26:0] f);
        logic chg = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            color_t c = f[r*3 +: 3];
`ifdef COLOR_STAB_HOLD_UNKNOWN_EN
            if (c == CODE_UNKNOWN) continue;
`endif
            hist[m][r].push_back(c);
            if (hist[m][r].size() > 300) void'(hist[m][r].pop_front());
            if (run_len(m, r) >= sfm[m] && mout[m][r] != c) begin
                mout[m][r] = c;
                chg = 1'b1;
            end
        end
        return chg;
    endfunction

    function automatic logic model_stable(input int m);
        logic s = 1'b1;
        for (int r = 0; r < NUM_REGIONS; r++)
            if (run_len(m, r) < sfm[m]) s = 1'b0;
        return s;
    endfunction

    function automatic logic [26:0] model_outs(input int m);
        logic [26:0] v = '0;
        for (int r = 0; r < NUM_REGIONS; r++) v[r*3 +: 3] = mout[m][r];
        return v;
    endfunction

    function automatic logic [26:0] biased(input logic [26:0] prev);
        logic [26:0] f = prev;
        for (int r = 0; r < NUM_REGIONS; r++)
            if ($urandom_range(3) == 0) f[r*3 +: 3] = 3'($urandom_range(7));
        return f;
    endfunction

    // called just after a negedge; returns just after the edge that samples the strobe
    task automatic start_frame(input int m, input logic [26:0] f);
        drive(m, 1'b1, f);
        @(negedge clk);
        drive(m, 1'b0, f);
        exp_upd[m] = model_frame(m, f);
        chk("busy_start", 32'(busy(m)), 32'd1);
    endtask

    task automatic finish_frame(input int m, input int extra, input logic [26:0] f);
        int seen = -1;
        int n = 0;
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (upd(m)) begin
                if (seen < 0) seen = j;
                n++;
            end
            drive(m, j == extra, f ^ 27'h5B6DB6D);
        end
        chk("upd_latency", 32'(seen), exp_upd[m] ? 32'd11 : 32'hFFFF_FFFF);
        chk("upd_pulses", 32'(n), 32'(exp_upd[m]));
        chk("colors", 32'(outs(m)), 32'(model_outs(m)));
        chk("all_stable", 32'(alls(m)), 32'(model_stable(m)));
        chk("busy_end", 32'(busy(m)), 32'd0);
    endtask

    initial begin
        logic [26:0] f;
        logic [26:0] cur [2];
        logic [2:0]  c0;
        logic [2:0]  exp_c0;
        logic        exp_a;

        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_colors", 32'(outs(m)), 32'h07FF_FFFF);
            chk("rst_flags", 32'({upd(m), busy(m), ovr(m), alls(m)}), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // stabilise: four identical frames, update only on the last
        f = {9{3'd3}};
        for (int i = 0; i < 4; i++) begin
            start_frame(0, f);
            finish_frame(0, 0, f);
            repeat (5) @(negedge clk);
        end
        chk("stab_colors", 32'(outs(0)), 32'({9{3'd3}}));
        chk("stab_all", 32'(alls(0)), 32'd1);

        // flicker on region 2, others settle on white
        for (int i = 0; i < 8; i++) begin
            f = {9{3'd5}};
            f[8:6] = (i % 2 == 0) ? 3'd1 : 3'd4;
            start_frame(0, f);
            finish_frame(0, 0, f);
        end
        f = outs(0);
        chk("flick_c2", 32'(f[8:6]), 32'd3);
        chk("flick_all", 32'(alls(0)), 32'd0);

        // overrun: dropped strobe mid-scan, sticky flag, next strobe accepted
        f = 27'($urandom);
        start_frame(0, f);
        finish_frame(0, 4, f);
        chk("ovr_set", 32'(ovr(0)), 32'd1);
        f = 27'($urandom);
        start_frame(0, f);
        finish_frame(0, 0, f);
        chk("ovr_sticky", 32'(ovr(0)), 32'd1);

        // reset in the middle of a scan
        start_frame(0, {9{3'd2}});
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("midrst_colors", 32'(outs(m)), 32'h07FF_FFFF);
            chk("midrst_flags", 32'({upd(m), busy(m), ovr(m), alls(m)}), 32'd0);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // region 0 sees 2,2,7,2,2
        for (int i = 0; i < 5; i++) begin
            f = '0;
            f[2:0] = (i == 2) ? 3'd7 : 3'd2;
            start_frame(0, f);
            finish_frame(0, 0, f);
        end
`ifdef COLOR_STAB_HOLD_UNKNOWN_EN
        exp_c0 = 3'd2;
`else
        exp_c0 = 3'd7;
`endif
        f = outs(0);
        c0 = f[2:0];
        chk("hold_c0", 32'(c0), 32'(exp_c0));

        // STABLE_FRAMES = 1: outputs follow in one frame
        f = {3'd7, 3'd7, 3'd7, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        start_frame(1, f);
        finish_frame(1, 0, f);
        chk("sf1_colors", 32'(outs(1)), 32'(f));

        // strobe in the first IDLE cycle after DONE is accepted
        start_frame(1, {9{3'd2}});
        exp_a = exp_upd[1];
        repeat (10) @(negedge clk);
        chk("b2b_idle", 32'(busy(1)), 32'd0);
        start_frame(1, {9{3'd4}});
        chk("b2b_prev_upd", 32'(upd(1)), 32'(exp_a));
        finish_frame(1, 0, {9{3'd4}});
        chk("b2b_no_ovr", 32'(ovr(1)), 32'd0);

        // randomized frames with mostly persistent codes
        cur[0] = 27'($urandom);
        cur[1] = 27'($urandom);
        for (int i = 0; i < 14; i++) begin
            for (int m = 0; m < 2; m++) begin
                cur[m] = biased(cur[m]);
                start_frame(m, cur[m]);
                finish_frame(m, 0, cur[m]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
